waterfall_arbiter: RTL

WATERFALL_ARBITER -- requirements
Module: waterfall_arbiter

---
 rtl/waterfall_arbiter_if.sv | 34 +++
 rtl/waterfall_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/waterfall_arbiter_if.sv
// Waterfall arbiter bus: video fetch, sample write, RAM port, commit.
interface waterfall_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
) ();
    logic          vid_req;
    logic [8:0]    vid_x;
    logic [7:0]    vid_y;
    logic          vid_vblank;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          commit;

    modport slave (
        input  vid_req, vid_x, vid_y, vid_vblank,
        input  wr_valid, wr_data, mem_rdata,
        output vid_valid, vid_data, wr_ready,
        output mem_addr, mem_we, mem_wdata, commit
    );

    modport master (
        output vid_req, vid_x, vid_y, vid_vblank,
        output wr_valid, wr_data, mem_rdata,
        input  vid_valid, vid_data, wr_ready,
        input  mem_addr, mem_we, mem_wdata, commit
    );
endinterface

// File: rtl/waterfall_arbiter.sv
// Single-port frame RAM arbiter: video reads win, ADC rows fill behind
// the top row and are committed on vblank.
module waterfall_arbiter #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int AW      = 17,
    parameter int DW      = 8
) (
    input logic                clk,
    input logic                resetn,
    waterfall_arbiter_if.slave bus
);
    typedef enum logic [1:0] {FILL, FULL, COMMIT} state_t;

    localparam logic [8:0] HP       = 9'(H_PIX);
    localparam logic [9:0] H_LIM    = 10'(H_PIX);
    localparam logic [8:0] V_LIM    = 9'(V_LINES);
    localparam logic [8:0] COL_LAST = 9'(H_PIX - 1);
    localparam logic [7:0] ROW_LAST = 8'(V_LINES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [8:0]    r_col;
    logic [7:0]    r_top;
    logic          r_vblank_d;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic          r_rd_p;
    logic          r_rd_ok;
    logic          r_vid_valid;
    logic [DW-1:0] r_vid_data;

    logic          w_in_range;
    logic [8:0]    w_sum;
    logic [7:0]    w_row;
    logic [7:0]    w_wrow;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;
    logic          w_wr_ready;
    logic          w_wr_acc;
    logic          w_vb_rise;
    logic          w_commit;

    // row * H_PIX built from shifted copies of row, one per set bit of H_PIX
    function automatic logic [AW-1:0] row_base(input logic [7:0] row);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            if (HP[i]) acc = acc + (AW'(row) << i);
        end
        return acc;
    endfunction

    assign w_in_range = ({1'b0, bus.vid_x} < H_LIM) &&
                        ({1'b0, bus.vid_y} < V_LIM);
    assign w_sum      = {1'b0, bus.vid_y} + {1'b0, r_top};
    assign w_row      = (w_sum >= V_LIM) ? 8'(w_sum - V_LIM) : w_sum[7:0];
    assign w_wrow     = (r_top == 8'd0) ? ROW_LAST : r_top - 8'd1;
    assign w_rd_addr  = row_base(w_row) + AW'(bus.vid_x);
    assign w_wr_addr  = row_base(w_wrow) + AW'(r_col);
    assign w_wr_ready = resetn && (r_state == FILL) && !bus.vid_req;
    assign w_wr_acc   = bus.wr_valid && w_wr_ready;
    assign w_vb_rise  = bus.vid_vblank && !r_vblank_d;

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        unique case (r_state)
            FILL:   if (w_wr_acc && r_col == COL_LAST) w_next = FULL;
            FULL:   if (w_vb_rise) w_next = COMMIT;
            COMMIT: begin
                w_next   = FILL;
                w_commit = 1'b1;
            end
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= FILL;
            r_col       <= '0;
            r_top       <= '0;
            r_vblank_d  <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_p      <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_vblank_d  <= bus.vid_vblank;
            r_rd_p      <= bus.vid_req;
            r_rd_ok     <= bus.vid_req && w_in_range;
            r_vid_valid <= r_rd_p;
            r_vid_data  <= r_rd_ok ? bus.mem_rdata : '0;
            r_mem_we    <= w_wr_acc;
            // out-of-range reads leave the address alone
            if (bus.vid_req) begin
                if (w_in_range) r_mem_addr <= w_rd_addr;
            end else if (w_wr_acc) begin
                r_mem_addr  <= w_wr_addr;
                r_mem_wdata <= bus.wr_data;
            end
            if (w_wr_acc) r_col <= (r_col == COL_LAST) ? '0 : r_col + 9'd1;
            if (r_state == COMMIT) r_top <= w_wrow;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.commit    = resetn && w_commit;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.vid_valid = r_vid_valid;
    assign bus.vid_data  = r_vid_data;
endmodule
